// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-back data cache:
// geometry parameters, controller state encoding and a byte-select helper.
package dcache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 8;
    localparam int BLOCK_W  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_e;

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                              input logic [OFFSET_W-1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Cache storage: per-line tag, valid, dirty and 4-byte data block, with one
// byte-write port (store hit) and one block-fill port (miss refill).
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  index,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [7:0]          byte_data,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data,
    output logic [TAG_W-1:0]    line_tag,
    output logic                line_valid,
    output logic                line_dirty,
    output logic [BLOCK_W-1:0]  line_data
);

    logic [LINES-1:0]              valid_r;
    logic [LINES-1:0]              dirty_r;
    logic [LINES-1:0][TAG_W-1:0]   tag_r;
    logic [LINES-1:0][BLOCK_W-1:0] data_r;

    // Status bits: reset clears them, a fill marks the line valid and clean.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_en) begin
            valid_r[index] <= 1'b1;
            dirty_r[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_r[index] <= 1'b1;
        end
    end

    // Tag/data arrays are not cleared; a reset cycle simply blocks updates.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fill_en) begin
                tag_r[index]  <= fill_tag;
                data_r[index] <= fill_data;
            end else if (byte_we) begin
                data_r[index][{byte_offset, 3'b000} +: 8] <= byte_data;
            end
        end
    end

    assign line_tag   = tag_r[index];
    assign line_valid = valid_r[index];
    assign line_dirty = dirty_r[index];
    assign line_data  = data_r[index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller: zero-stall
// hits in IDLE, otherwise optional WRITEBACK, FETCH and a one-cycle UPDATE.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        READ,
    input  logic                        WRITE,
    input  logic [7:0]                  ADDRESS,
    input  logic [7:0]                  WRITEDATA,
    output logic [7:0]                  READDATA,
    output logic                        BUSYWAIT,
    output logic                        MEM_READ,
    output logic                        MEM_WRITE,
    output logic [TAG_W+INDEX_W-1:0]    MEM_ADDRESS,
    output logic [BLOCK_W-1:0]          MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]          MEM_READDATA,
    input  logic                        MEM_BUSYWAIT
);

    state_e                     state_r;
    state_e                     state_s;
    logic [TAG_W+INDEX_W-1:0]   miss_blk_r;
    logic [INDEX_W-1:0]         index_s;
    logic                       req_s;
    logic                       hit_s;
    logic                       byte_we_s;
    logic                       fill_en_s;
    logic [TAG_W-1:0]           line_tag_s;
    logic                       line_valid_s;
    logic                       line_dirty_s;
    logic [BLOCK_W-1:0]         line_data_s;

    // The missing block address is latched so a dropped request cannot
    // redirect a transfer already in flight.
    assign index_s = (state_r == IDLE) ? ADDRESS[4:2] : miss_blk_r[INDEX_W-1:0];
    assign req_s   = READ | WRITE;
    assign hit_s   = req_s && line_valid_s && (line_tag_s == ADDRESS[7:5]);

    dcache_line_array u_lines (
        .CLK         (CLK),
        .RESET       (RESET),
        .index       (index_s),
        .byte_we     (byte_we_s),
        .byte_offset (ADDRESS[1:0]),
        .byte_data   (WRITEDATA),
        .fill_en     (fill_en_s),
        .fill_tag    (miss_blk_r[TAG_W+INDEX_W-1:INDEX_W]),
        .fill_data   (MEM_READDATA),
        .line_tag    (line_tag_s),
        .line_valid  (line_valid_s),
        .line_dirty  (line_dirty_s),
        .line_data   (line_data_s)
    );

    // State register and miss-address capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= IDLE;
            miss_blk_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && req_s && !hit_s) begin
                miss_blk_r <= ADDRESS[7:2];
            end
        end
    end

    // Next-state decode and all CPU/memory-side outputs.
    always_comb begin
        state_s       = state_r;
        READDATA      = 8'h00;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        byte_we_s     = 1'b0;
        fill_en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    if (WRITE) begin
                        byte_we_s = 1'b1;
                    end else begin
                        READDATA = block_byte(line_data_s, ADDRESS[1:0]);
                    end
                end else if (req_s) begin
                    BUSYWAIT = 1'b1;
                    state_s  = (line_valid_s && line_dirty_s) ? WRITEBACK : FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag_s, miss_blk_r[INDEX_W-1:0]};
                MEM_WRITEDATA = line_data_s;
                if (!MEM_BUSYWAIT) begin
                    state_s = FETCH;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = miss_blk_r;
                if (!MEM_BUSYWAIT) begin
                    fill_en_s = 1'b1;
                    state_s   = UPDATE;
                end else begin
                    state_s = FETCH;
                end
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                state_s  = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule
